// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
// Access widths, MMIO word offsets, STATUS bit positions and lane helpers.
package dmem_pkg;

  // rwtype_i encodings; 2'b11 behaves as a word access
  localparam logic [1:0] RW_BYTE     = 2'b00;
  localparam logic [1:0] RW_HALF     = 2'b01;
  localparam logic [1:0] RW_WORD     = 2'b10;
  localparam logic [1:0] RW_WORD_ALT = 2'b11;

  // MMIO register word indices relative to MMIO_BASE (byte offset / 4)
  localparam logic [9:0] MMIO_W_CYCLE_LO = 10'd0;  // 0x00
  localparam logic [9:0] MMIO_W_CYCLE_HI = 10'd1;  // 0x04
  localparam logic [9:0] MMIO_W_TX       = 10'd2;  // 0x08
  localparam logic [9:0] MMIO_W_STATUS   = 10'd3;  // 0x0C
  localparam logic [9:0] MMIO_W_SCRATCH  = 10'd4;  // 0x10

  // STATUS register layout
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_MISALIGN  = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 5;

  // Byte-lane enables for an aligned access at low address bits a
  function automatic logic [3:0] lane_enables(input logic [1:0] rwtype, input logic [1:0] a);
    case (rwtype)
      RW_BYTE: lane_enables = 4'b0001 << a;
      RW_HALF: lane_enables = a[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes; enables pick the lane
  function automatic logic [31:0] lane_data(input logic [1:0] rwtype, input logic [31:0] wd);
    case (rwtype)
      RW_BYTE: lane_data = {4{wd[7:0]}};
      RW_HALF: lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] rwtype, input logic [1:0] a);
    case (rwtype)
      RW_BYTE: is_misaligned = 1'b0;
      RW_HALF: is_misaligned = a[0];
      default: is_misaligned = |a;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: core data-memory port plus the console byte stream.
// Console handshake: a byte transfers on a rising edge where tx_valid_o and
// tx_ready_i are both 1; tx_valid_o never depends on tx_ready_i, and while
// tx_valid_o=1 and tx_ready_i=0 the head byte on tx_data_o is held stable.
interface dmem_if;
  logic        mem_wr_i;
  logic [1:0]  rwtype_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;

  modport slave (
    input  mem_wr_i, rwtype_i, addr_i, wdata_i, tx_ready_i,
    output rdata_o, tx_valid_o, tx_data_o
  );

  modport master (
    output mem_wr_i, rwtype_i, addr_i, wdata_i, tx_ready_i,
    input  rdata_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/dmem_tx_fifo.sv
// dmem_tx_fifo: console byte FIFO, registered (not fall-through).
// A push while full is accepted only if the head pops in the same cycle.
module dmem_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   push_ok_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop;

  assign valid_o   = (count_q != '0);
  assign pop       = valid_o & ready_i;
  assign push_ok_o = push_i & ((count_q < DEPTH_C) | pop);
  assign data_o    = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o   = count_q;
  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);

  // Pointer and occupancy next state; power-of-two depth wraps naturally
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push_ok_o, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes the queue
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; data_o is masked while empty
  always_ff @(posedge clk_i) begin
    if (rstn_i && push_ok_o) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: RAM + MMIO responder on the RV32 core's data-memory port.
// Optional console FIFO built only when DMEM_CONSOLE_EN is defined.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   halt_i,
  dmem_if.slave  bus
);
  localparam int         RAM_WORDS  = int'(MMIO_BASE) >> 2;
  localparam logic [9:0] MMIO_WBASE = MMIO_BASE[11:2];

  logic [31:0] ram_q [RAM_WORDS];
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic        misalign_q, misalign_d, overflow_q, overflow_d;

  logic        is_ram, misalign, wr_ok;
  logic [9:0]  off_w;
  logic [3:0]  be;
  logic [31:0] wlane, status, rdata;
  logic        ram_we, tx_push, status_wr, scratch_wr, ovf_set;
  logic        st_full, st_empty;
  logic [4:0]  st_count;

  assign is_ram     = (bus.addr_i < MMIO_BASE);
  assign off_w      = bus.addr_i[11:2] - MMIO_WBASE;
  assign misalign   = bus.mem_wr_i & is_misaligned(bus.rwtype_i, bus.addr_i[1:0]);
  assign wr_ok      = bus.mem_wr_i & ~misalign;
  assign be         = lane_enables(bus.rwtype_i, bus.addr_i[1:0]);
  assign wlane      = lane_data(bus.rwtype_i, bus.wdata_i);
  assign ram_we     = wr_ok & is_ram;
  assign tx_push    = wr_ok & ~is_ram & (off_w == MMIO_W_TX);
  assign status_wr  = wr_ok & ~is_ram & (off_w == MMIO_W_STATUS);
  assign scratch_wr = wr_ok & ~is_ram & (off_w == MMIO_W_SCRATCH);

`ifdef DMEM_CONSOLE_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] fifo_count;
  logic          push_ok;

  dmem_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .push_i    (tx_push),
    .data_i    (bus.wdata_i[7:0]),
    .ready_i   (bus.tx_ready_i),
    .valid_o   (bus.tx_valid_o),
    .data_o    (bus.tx_data_o),
    .count_o   (fifo_count),
    .full_o    (st_full),
    .empty_o   (st_empty),
    .push_ok_o (push_ok)
  );
  assign st_count = 5'(fifo_count);
  assign ovf_set  = tx_push & ~push_ok;
`else
  logic unused_console;
  assign unused_console = tx_push | bus.tx_ready_i;
  assign bus.tx_valid_o = 1'b0;
  assign bus.tx_data_o  = 8'h00;
  assign st_full        = 1'b0;
  assign st_empty       = 1'b1;
  assign st_count       = 5'd0;
  assign ovf_set        = 1'b0;
`endif

  // Next state for counter, scratch and sticky flags; misalign wins over a clear
  always_comb begin
    cycle_d    = halt_i ? cycle_q : cycle_q + 64'd1;
    scratch_d  = scratch_q;
    misalign_d = misalign_q;
    overflow_d = overflow_q;
    if (status_wr) begin
      misalign_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (misalign) misalign_d = 1'b1;
    if (ovf_set)  overflow_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (scratch_wr && be[i]) scratch_d[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  // MMIO state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cycle_q    <= 64'd0;
      scratch_q  <= 32'd0;
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      misalign_q <= misalign_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM byte-lane writes; a write during reset is discarded
  always_ff @(posedge clk_i) begin
    if (rstn_i && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_q[bus.addr_i[11:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status = 32'd0;
    status[ST_FULL]     = st_full;
    status[ST_EMPTY]    = st_empty;
    status[ST_MISALIGN] = misalign_q;
    status[ST_OVERFLOW] = overflow_q;
    status[ST_COUNT_LSB +: ST_COUNT_W] = st_count;
  end

  // Combinational read of the aligned word at addr_i
  always_comb begin
    rdata = 32'd0;
    if (is_ram) begin
      rdata = ram_q[bus.addr_i[11:2]];
    end else begin
      case (off_w)
        MMIO_W_CYCLE_LO: rdata = cycle_q[31:0];
        MMIO_W_CYCLE_HI: rdata = cycle_q[63:32];
        MMIO_W_STATUS:   rdata = status;
        MMIO_W_SCRATCH:  rdata = scratch_q;
        default:         rdata = 32'd0;
      endcase
    end
  end

  assign bus.rdata_o = rdata;
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-cycle RV32 core: the slave end of the core's load/store port (write enable, width type, 12-bit byte address, write data, read data). Holds a 3840-byte RAM plus a small MMIO window with a free-running cycle counter, a scratch register, a status register, and a console byte FIFO drained by a valid/ready handshake toward the host or test harness. Sits beside the core at top level, wired directly to its data-memory port.

## Interface
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..16
- MMIO_BASE, 12'hF00, first MMIO byte address; RAM occupies 0x000..MMIO_BASE-1
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; synchronous, active-low
- mem_wr_i  in  1  1 = write this cycle, 0 = read
- rwtype_i  in  2  access width: 00 byte, 01 half, 10 word, 11 treated as word
- addr_i  in  12  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rdata_o  out  32  full aligned word at addr_i[11:2]; core selects lanes
- halt_i  in  1  core ebreak; freezes cycle counter
- tx_valid_o  out  1  FIFO head valid
- tx_data_o  out  8  FIFO head byte
- tx_ready_i  in  1  host accepts head byte

## Operation
- Reads combinational, same cycle, no side effects. Unmapped MMIO offsets read 0.
- Writes commit on rising edge when mem_wr_i=1. Byte/half data shifted into lane by addr_i[1:0], with per-byte enables.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0): write dropped, STATUS.misalign set. Reads are never checked.
- MMIO offsets from MMIO_BASE:
  - 0x00 CYCLE_LO, RO
  - 0x04 CYCLE_HI, RO
  - 0x08 CONSOLE_TX, WO; any width pushes wdata_i[7:0]
  - 0x0C STATUS, RO bits: [0] full, [1] empty, [2] misalign sticky, [3] overflow sticky, [8:4] count. Any write clears bits 2 and 3.
  - 0x10 SCRATCH, RW, byte-lane enables honoured
  - writes elsewhere ignored
- Cycle counter: 64-bit, +1 every cycle while halt_i=0, wraps to 0 from all-ones. LO/HI reads are not atomic.
- FIFO rules:
  - Pop on tx_valid_o & tx_ready_i.
  - Push accepted if count<FIFO_DEPTH or a pop occurs in the same cycle.
  - Rejected push sets overflow; the byte is lost.

## Timing
- Reset values:
  - rdata_o tracks the current address; RAM contents are not reset
  - tx_valid_o=0, tx_data_o=0
  - counter=0, SCRATCH=0, FIFO empty, sticky bits 0
- Write-to-read latency: 1 cycle; a write at edge N is visible on rdata_o after edge N.
- FIFO is not fall-through: a push into an empty FIFO raises tx_valid_o the cycle after the push edge.
- tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- Simultaneous push and pop at any count: count unchanged, order preserved.
- Reset asserted mid-transfer: FIFO flushed, tx_valid_o=0 on the next edge; a write in the same cycle as reset is discarded.
- halt_i freezes only the counter; memory and FIFO keep operating.

## Configuration
- DMEM_CONSOLE_EN defined: console FIFO and handshake as above.
- Undefined: no FIFO logic.
  - CONSOLE_TX writes ignored
  - tx_valid_o=0, tx_data_o=0
  - STATUS reads full=0, empty=1, count=0, overflow=0

## Structure
- Package dmem_pkg holds:
  - rwtype encodings
  - MMIO offset constants
  - STATUS bit positions
- One sub-module, dmem_tx_fifo: parameterized depth, synchronous push/pop, count/full/empty outputs. Only instantiated under DMEM_CONSOLE_EN.
- RAM array and MMIO decode stay in dmem_resp.

## Test plan
- Store word 0xDEADBEEF at 0x010, then byte 0x55 at 0x011 -> read 0x010 returns 0xDEAD55EF.
- Half store 0x1234 at 0x022, then half store at 0x023 -> read 0x020 shows [31:16]=0x1234; STATUS bit2=1; STATUS write clears it.
- Reset, wait 100 cycles, assert halt_i for 5 cycles -> CYCLE_LO reads 100 throughout the halt, then resumes incrementing.
- tx_ready_i=0, push 9 bytes 0x41..0x49 with depth 8 -> STATUS full=1, count=8, overflow=1; raise ready -> bytes 0x41..0x48 emerge in order, one per cycle.
- FIFO at count 8 with tx_ready_i=1 and a push in the same cycle -> push accepted, count stays 8, no overflow.
- Assert reset while tx_valid_o=1 -> next cycle tx_valid_o=0, count=0, SCRATCH=0; with DMEM_CONSOLE_EN undefined, pushes leave tx_valid_o=0 and STATUS empty=1.
